// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - programmable down-counting phase timer with prescaler, pause, abort and auto-reload
module cycle_timer #(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 4,
  parameter int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] warn_thresh,
  output logic             busy,
  output logic             paused,
  output logic [CNT_W-1:0] remaining,
  output logic             warn,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] thresh;
  logic             mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pre       <= '0;
      remaining <= '0;
      reload    <= '0;
      thresh    <= '0;
      mode      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (load_val != '0) begin
              reload    <= load_val;
              thresh    <= warn_thresh;
              mode      <= periodic;
              remaining <= load_val;
              pre       <= '0;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        // RUN and PAUSE share one path: releasing pause counts on that same
        // edge, so every cycle with pause high costs exactly one cycle.
        RUN, PAUSE: begin
          if (abort) begin
            state     <= IDLE;
            remaining <= '0;
            pre       <= '0;
          end else if (pause) begin
            state <= PAUSE;
          end else if (pre == PRE_MAX) begin
            pre <= '0;
            if (remaining > ONE) begin
              remaining <= remaining - ONE;
              state     <= RUN;
            end else if (mode) begin
              remaining <= reload;
              done      <= 1'b1;
              state     <= RUN;
            end else begin
              remaining <= '0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            pre   <= pre + PRE_W'(1);
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = (state == RUN) || (state == PAUSE);
  assign paused = (state == PAUSE);
  assign warn   = busy && (remaining != '0) && (remaining <= thresh);

endmodule
